// File: rtl/instr_reg_seq_ctrl_pkg.sv
// Shared types for the instruction-register sequencer: register payload types,
// controller FSM states and the pointer wrap helper.
package instr_reg_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH
    } ctrl_state_t;

    localparam int REG_DEPTH = 32;

    // Pointers wrap at the configured depth, which may be smaller than the register.
    function automatic address_t ptr_next(input address_t ptr, input address_t last);
        return (ptr == last) ? address_t'(0) : address_t'(ptr + 1'b1);
    endfunction

endpackage

// File: rtl/instr_reg_seq_ctrl_if.sv
// Bundle of the push, pop and register-side signals of the sequencer.
// The slave modport is the controller; the master modport is its environment.
interface instr_reg_seq_ctrl_if #(
    parameter int DEPTH = 32
);
    import instr_reg_seq_ctrl_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    opcode_t            in_opcode;
    operand_t           in_op_a;
    operand_t           in_op_b;
    logic               flush;
    logic               load_en;
    address_t           write_pointer;
    address_t           read_pointer;
    opcode_t            opcode;
    operand_t           operand_a;
    operand_t           operand_b;
    instruction_t       instruction_word;
    logic               out_valid;
    logic               out_ready;
    instruction_t       out_instr;
    logic [CW-1:0]      count;

    modport slave (
        input  in_valid, in_opcode, in_op_a, in_op_b, flush, out_ready, instruction_word,
        output in_ready, load_en, write_pointer, read_pointer, opcode, operand_a, operand_b,
               out_valid, out_instr, count
    );

    modport master (
        output in_valid, in_opcode, in_op_a, in_op_b, flush, out_ready, instruction_word,
        input  in_ready, load_en, write_pointer, read_pointer, opcode, operand_a, operand_b,
               out_valid, out_instr, count
    );

endinterface

// File: rtl/instr_reg_seq_ctrl.sv
// Runs the 32-entry instruction register as an in-order FIFO between decode (push)
// and execute (pop); owns load_en, both pointers and the occupancy count.
module instr_reg_seq_ctrl #(
    parameter int DEPTH       = 32,
    parameter int INIT_CYCLES = 2
) (
    input logic                clk,
    input logic                reset_n,
    instr_reg_seq_ctrl_if.slave bus
);
    import instr_reg_seq_ctrl_pkg::*;

    localparam int                CW        = $clog2(DEPTH) + 1;
    localparam int                IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam address_t          LAST_ADDR = address_t'(DEPTH - 1);
    localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);
    localparam logic [IW-1:0]     INIT_LAST = IW'(INIT_CYCLES - 1);

    ctrl_state_t    r_state;
    ctrl_state_t    w_state_next;
    logic [IW-1:0]  r_init_cnt;
    address_t       r_wr_ptr;
    address_t       r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_flush_take;
    logic w_push;
    logic w_pop;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_flush_take = 1'b0;
        case (r_state)
            INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_in_ready  = !bus.flush && (r_count < FULL_CNT);
                w_out_valid = (r_count != '0);
                if (bus.flush) begin
                    w_flush_take = 1'b1;
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    // A flush cycle blocks the pop even though out_valid stays visible.
    assign w_push = bus.in_valid & w_in_ready;
    assign w_pop  = w_out_valid & bus.out_ready & ~bus.flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush_take) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr, LAST_ADDR);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr, LAST_ADDR);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.load_en       = w_push;
    assign bus.write_pointer = r_wr_ptr;
    assign bus.read_pointer  = r_rd_ptr;
    assign bus.count         = r_count;
    assign bus.opcode        = bus.in_opcode;
    assign bus.operand_a     = bus.in_op_a;
    assign bus.operand_b     = bus.in_op_b;
    assign bus.out_instr     = bus.instruction_word;

endmodule

// File: tb/tb_instr_reg_seq_ctrl.sv
// Scoreboard bench for instr_reg_seq_ctrl: a behavioural instruction register sits
// behind the controller; pushes queue expectations, a monitor checks every pop.
`timescale 1ns/1ps
module tb_instr_reg_seq_ctrl;
    import instr_reg_seq_ctrl_pkg::*;

    typedef struct {
        instruction_t ins;
        address_t     addr;
    } sb_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    bit   done;
    sb_t  sb_q[$];
    address_t exp_wp;
    instruction_t reg_mem [REG_DEPTH];

    instr_reg_seq_ctrl_if #(.DEPTH(32)) bus ();

    instr_reg_seq_ctrl #(.DEPTH(32), .INIT_CYCLES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.load_en) begin
            reg_mem[bus.write_pointer] <= {bus.opcode, bus.operand_a, bus.operand_b};
        end
    end
    assign bus.instruction_word = reg_mem[bus.read_pointer];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instruction_t mk(input int i);
        instruction_t t;
        t.opc  = opcode_t'(4'(i % 8));
        t.op_a = operand_t'(i * 7 - 50);
        t.op_b = operand_t'(i ^ 32'h5a5a);
        return t;
    endfunction

    function automatic address_t wrap_inc(input address_t a);
        return (a == address_t'(31)) ? address_t'(0) : address_t'(a + 1'b1);
    endfunction

    task automatic push_one(input instruction_t ins, input logic exp_rdy, input string nm);
        bus.in_valid  = 1'b1;
        bus.in_opcode = ins.opc;
        bus.in_op_a   = ins.op_a;
        bus.in_op_b   = ins.op_b;
        @(negedge clk);
        check({nm, "_in_ready"}, bus.in_ready, exp_rdy);
        check({nm, "_load_en"}, bus.load_en, exp_rdy);
        if (exp_rdy) begin
            check({nm, "_wr_addr"}, bus.write_pointer, exp_wp);
            sb_q.push_back('{ins, exp_wp});
            exp_wp = wrap_inc(exp_wp);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        repeat (n) tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (!done && bus.out_valid && bus.out_ready && !bus.flush) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected: got %0h expected no entry", bus.out_instr);
                end else begin
                    e = sb_q.pop_front();
                    check("pop_data", bus.out_instr, e.ins);
                    check("pop_addr", bus.read_pointer, e.addr);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        checks = 0; failures = 0; done = 1'b0; exp_wp = '0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_opcode = ZERO; bus.in_op_a = '0; bus.in_op_b = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_load_en", bus.load_en, 0);
        check("rst_count", bus.count, 0);
        check("rst_wp", bus.write_pointer, 0);
        check("rst_rp", bus.read_pointer, 0);
        tick();

        // Init: in_valid held from release; two cycles of in_ready=0, push in cycle 3
        reset_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_opcode = ADD; bus.in_op_a = 5; bus.in_op_b = 3;
        @(negedge clk);
        check("init_c1_in_ready", bus.in_ready, 0);
        check("init_c1_load_en", bus.load_en, 0);
        tick();
        @(negedge clk);
        check("init_c2_in_ready", bus.in_ready, 0);
        tick();
        push_one(instruction_t'{ADD, 32'sd5, 32'sd3}, 1'b1, "init_c3");

        // Ordering
        push_one(instruction_t'{SUB, -32'sd7, 32'sd2}, 1'b1, "ord_sub");
        push_one(instruction_t'{MULT, 32'sd4, 32'sd4}, 1'b1, "ord_mult");
        @(negedge clk);
        check("ord_count3", bus.count, 3);
        check("ord_out_valid", bus.out_valid, 1);
        tick();
        drain(3);
        @(negedge clk);
        check("ord_count0", bus.count, 0);
        check("ord_empty_valid", bus.out_valid, 0);
        check("ord_rp", bus.read_pointer, 3);
        tick();

        // Flush with 7 queued
        for (int i = 0; i < 7; i++) push_one(mk(i), 1'b1, "fl_push");
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check("fl_count7", bus.count, 7);
        check("fl_in_ready", bus.in_ready, 0);
        check("fl_load_en", bus.load_en, 0);
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        sb_q.delete();
        exp_wp = '0;
        @(negedge clk);
        check("fl_count", bus.count, 0);
        check("fl_wp", bus.write_pointer, 0);
        check("fl_rp", bus.read_pointer, 0);
        check("fl_out_valid", bus.out_valid, 0);
        check("fl_state_in_ready", bus.in_ready, 0);
        tick();
        @(negedge clk);
        check("fl_resume_in_ready", bus.in_ready, 1);
        tick();

        // Full: 32 pushes, pop while full, 33rd push lands at address 0
        for (int i = 0; i < 32; i++) push_one(mk(100 + i), 1'b1, "full_push");
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check("full_count", bus.count, 32);
        check("full_in_ready", bus.in_ready, 0);
        check("full_out_valid", bus.out_valid, 1);
        tick();
        bus.out_ready = 1'b0;
        push_one(mk(200), 1'b1, "full_resume");
        @(negedge clk);
        check("full_wp_after33", bus.write_pointer, 1);
        check("full_count_again", bus.count, 32);
        tick();
        drain(32);
        @(negedge clk);
        check("full_drained", bus.count, 0);
        tick();

        // Simultaneous push+pop at count=5
        for (int i = 0; i < 5; i++) push_one(mk(300 + i), 1'b1, "sim_push");
        bus.out_ready = 1'b1;
        push_one(mk(310), 1'b1, "sim_pushpop");
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("sim_count", bus.count, 5);
        check("sim_wp", bus.write_pointer, 7);
        check("sim_rp", bus.read_pointer, 2);
        tick();

        // Wrap: 40 push/pop pairs
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) push_one(mk(400 + i), 1'b1, "wrap_pair");
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("wrap_count", bus.count, 5);
        check("wrap_wp", bus.write_pointer, 15);
        check("wrap_rp", bus.read_pointer, 10);
        tick();
        drain(5);
        @(negedge clk);
        check("wrap_drained", bus.count, 0);
        check("sb_empty", sb_q.size(), 0);
        tick();

        // Reset mid-burst
        push_one(mk(500), 1'b1, "rb_push");
        push_one(mk(501), 1'b1, "rb_push");
        bus.in_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        @(negedge clk);
        check("rb_in_ready", bus.in_ready, 0);
        check("rb_out_valid", bus.out_valid, 0);
        check("rb_load_en", bus.load_en, 0);
        check("rb_count", bus.count, 0);
        check("rb_wp", bus.write_pointer, 0);
        check("rb_rp", bus.read_pointer, 0);
        bus.in_valid = 1'b0;
        tick();

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
